// File: rtl/rf_wb_pkg.sv
// Shared widths and the buffered write-result record for the RF write-back path.
package rf_wb_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 2;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// Circular buffer of write-back entries; exposes the raw storage and read pointer
// so the owner can pick the head and search entries for forwarding.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  wb_entry_t             wr_entry,
    output wb_entry_t [DEPTH-1:0] entries,
    output logic [PW-1:0]         rd_ptr,
    output logic [PW:0]           count,
    output logic                  full,
    output logic                  empty
);
    wb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         wr_ptr;

    // Storage needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    assign entries = mem;
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
endmodule

// File: rtl/rf_writeback.sv
// Write-side initiator for the register file: buffers results, drains one per clock,
// and flags registers with pending writes. Define RF_WB_BYPASS_EN for read forwarding.
module rf_writeback
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                clk,
    input  logic                reset,
`ifdef RF_WB_BYPASS_EN
    input  logic [ADDR_W-1:0]   q_addr1,
    input  logic [ADDR_W-1:0]   q_addr2,
    output logic                hit1,
    output logic                hit2,
    output logic [DATA_W-1:0]   fwd_data1,
    output logic [DATA_W-1:0]   fwd_data2,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                rf_stall,
    input  logic                flush,
    output logic                rf_write,
    output logic [ADDR_W-1:0]   rf_addr,
    output logic [DATA_W-1:0]   rf_data,
    output logic [NUM_REGS-1:0] busy,
    output logic                empty,
    output logic [CW-1:0]       count
);
    wb_entry_t [DEPTH-1:0]        entries;
    wb_entry_t                    head;
    logic [PW-1:0]                rd_ptr;
    logic                         full;
    logic                         push;
    logic                         pop;
    logic [NUM_REGS-1:0][CW-1:0]  pend_cnt;

    // Readiness ignores a same-cycle pop, so a full buffer never takes a push.
    assign in_ready = !full && !flush && !reset;
    assign rf_write = !empty && !rf_stall && !flush && !reset;
    assign push     = in_valid && in_ready;
    assign pop      = rf_write;

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wr_entry ('{addr: in_addr, data: in_data}),
        .entries  (entries),
        .rd_ptr   (rd_ptr),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign head    = entries[rd_ptr];
    assign rf_addr = head.addr;
    assign rf_data = head.data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_cnt <= '0;
        end else if (flush) begin
            pend_cnt <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                pend_cnt[r] <= pend_cnt[r]
                             + CW'(push && (in_addr == ADDR_W'(r)))
                             - CW'(pop && (head.addr == ADDR_W'(r)));
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 0; r < NUM_REGS; r++)
            busy[r] = (pend_cnt[r] != '0);
    end

`ifdef RF_WB_BYPASS_EN
    logic [PW-1:0] idx;

    // Walk oldest to youngest so the last match is the youngest entry.
    always_comb begin
        hit1      = 1'b0;
        hit2      = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if (entries[idx].addr == q_addr1) begin
                    hit1      = 1'b1;
                    fwd_data1 = entries[idx].data;
                end
                if (entries[idx].addr == q_addr2) begin
                    hit2      = 1'b1;
                    fwd_data2 = entries[idx].data;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_rf_writeback;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_addr;
    logic [15:0] in_data;
    logic        rf_stall;
    logic        flush;
    logic        rf_write;
    logic [1:0]  rf_addr;
    logic [15:0] rf_data;
    logic [3:0]  busy;
    logic        empty;
    logic [2:0]  count;
    logic [1:0]  q_addr1, q_addr2;
`ifdef RF_WB_BYPASS_EN
    logic        hit1, hit2;
    logic [15:0] fwd_data1, fwd_data2;
`endif

    int pass_cnt = 0;
    int total    = 0;

    rf_writeback #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef RF_WB_BYPASS_EN
        .q_addr1   (q_addr1),
        .q_addr2   (q_addr2),
        .hit1      (hit1),
        .hit2      (hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .rf_stall  (rf_stall),
        .flush     (flush),
        .rf_write  (rf_write),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .busy      (busy),
        .empty     (empty),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  a;
        logic [15:0] d;
    } ent_t;
    ent_t mq[$];

    typedef struct {
        logic v; logic [1:0] a; logic [15:0] d; logic st; logic fl;
        logic ew; logic [1:0] ea; logic [15:0] ed; logic [3:0] eb; logic [2:0] ec; logic er;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    endtask

    task automatic apply(input logic v, input logic [1:0] a, input logic [15:0] d,
                         input logic st, input logic fl);
        in_valid = v; in_addr = a; in_data = d; rf_stall = st; flush = fl;
        #1;
    endtask

    // Advance one edge and update the model from the rules: flush clears,
    // otherwise an unstalled non-empty buffer pops and a non-full buffer accepts.
    task automatic tick();
        bit mr, mw;
        ent_t e;
        mr = (mq.size() < DEPTH) && !flush;
        mw = (mq.size() > 0) && !rf_stall && !flush;
        e.a = in_addr; e.d = in_data;
        @(posedge clk);
        if (flush) mq.delete();
        else begin
            if (mw) void'(mq.pop_front());
            if (in_valid && mr) mq.push_back(e);
        end
        #1;
    endtask

    task automatic check_model();
        logic [3:0] eb;
        bit mw;
        eb = '0;
        foreach (mq[i]) eb[mq[i].a] = 1'b1;
        mw = (mq.size() > 0) && !rf_stall && !flush;
        chk("m_ready", in_ready, (mq.size() < DEPTH) && !flush);
        chk("m_write", rf_write, mw);
        chk("m_count", count, mq.size());
        chk("m_empty", empty, mq.size() == 0);
        chk("m_busy", busy, eb);
        if (mq.size() > 0) begin
            chk("m_addr", rf_addr, mq[0].a);
            chk("m_data", rf_data, mq[0].d);
        end
`ifdef RF_WB_BYPASS_EN
        begin
            logic h1, h2; logic [15:0] f1, f2;
            h1 = 0; h2 = 0; f1 = 0; f2 = 0;
            foreach (mq[i]) begin
                if (mq[i].a == q_addr1) begin h1 = 1; f1 = mq[i].d; end
                if (mq[i].a == q_addr2) begin h2 = 1; f2 = mq[i].d; end
            end
            chk("m_hit1", hit1, h1); chk("m_fwd1", fwd_data1, f1);
            chk("m_hit2", hit2, h2); chk("m_fwd2", fwd_data2, f2);
        end
`endif
    endtask

    initial begin
        reset = 1'b1; in_valid = 0; in_addr = 0; in_data = 0; rf_stall = 0; flush = 0;
        q_addr1 = 0; q_addr2 = 0;

        //           v a  d        st fl  ew ea ed       eb       ec er
        vecs.push_back('{1, 2, 16'h1234, 0, 0,  0, 0, 16'h0,    4'b0000, 0, 1});
        vecs.push_back('{0, 0, 16'h0,    0, 0,  1, 2, 16'h1234, 4'b0100, 1, 1});
        vecs.push_back('{0, 0, 16'h0,    0, 0,  0, 0, 16'h0,    4'b0000, 0, 1});
        vecs.push_back('{1, 0, 16'hA000, 1, 0,  0, 0, 16'h0,    4'b0000, 0, 1});
        vecs.push_back('{1, 1, 16'hA001, 1, 0,  0, 0, 16'h0,    4'b0001, 1, 1});
        vecs.push_back('{1, 2, 16'hA002, 1, 0,  0, 0, 16'h0,    4'b0011, 2, 1});
        vecs.push_back('{1, 3, 16'hA003, 1, 0,  0, 0, 16'h0,    4'b0111, 3, 1});
        vecs.push_back('{1, 0, 16'hBEEF, 1, 0,  0, 0, 16'h0,    4'b1111, 4, 0});
        vecs.push_back('{0, 0, 16'h0,    0, 0,  1, 0, 16'hA000, 4'b1111, 4, 0});
        vecs.push_back('{0, 0, 16'h0,    0, 0,  1, 1, 16'hA001, 4'b1110, 3, 1});
        vecs.push_back('{0, 0, 16'h0,    0, 0,  1, 2, 16'hA002, 4'b1100, 2, 1});
        vecs.push_back('{0, 0, 16'h0,    0, 0,  1, 3, 16'hA003, 4'b1000, 1, 1});
        vecs.push_back('{0, 0, 16'h0,    0, 0,  0, 0, 16'h0,    4'b0000, 0, 1});
        vecs.push_back('{1, 3, 16'hC000, 1, 0,  0, 0, 16'h0,    4'b0000, 0, 1});
        vecs.push_back('{1, 2, 16'hC001, 1, 0,  0, 0, 16'h0,    4'b1000, 1, 1});
        vecs.push_back('{1, 1, 16'hC002, 1, 0,  0, 0, 16'h0,    4'b1100, 2, 1});
        vecs.push_back('{1, 0, 16'hC003, 1, 0,  0, 0, 16'h0,    4'b1110, 3, 1});
        vecs.push_back('{0, 0, 16'h0,    0, 0,  1, 3, 16'hC000, 4'b1111, 4, 0});
        vecs.push_back('{0, 0, 16'h0,    0, 0,  1, 2, 16'hC001, 4'b0111, 3, 1});
        vecs.push_back('{0, 0, 16'h0,    0, 0,  1, 1, 16'hC002, 4'b0011, 2, 1});
        vecs.push_back('{0, 0, 16'h0,    0, 0,  1, 0, 16'hC003, 4'b0001, 1, 1});
        vecs.push_back('{0, 0, 16'h0,    0, 0,  0, 0, 16'h0,    4'b0000, 0, 1});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_write", rf_write, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        #1;
        chk("rel_ready", in_ready, 1);

        foreach (vecs[i]) begin
            apply(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].st, vecs[i].fl);
            chk($sformatf("v%0d_write", i), rf_write, vecs[i].ew);
            chk($sformatf("v%0d_count", i), count, vecs[i].ec);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].eb);
            chk($sformatf("v%0d_ready", i), in_ready, vecs[i].er);
            chk($sformatf("v%0d_empty", i), empty, vecs[i].ec == 0);
            if (vecs[i].ew) begin
                chk($sformatf("v%0d_addr", i), rf_addr, vecs[i].ea);
                chk($sformatf("v%0d_data", i), rf_data, vecs[i].ed);
            end
            tick();
        end

        // Reset asserted mid-stream with two entries buffered.
        apply(1, 1, 16'h1111, 1, 0); tick();
        apply(1, 2, 16'h2222, 1, 0); tick();
        apply(0, 0, 16'h0, 0, 0);
        chk("pre_rst_count", count, 2);
        #1; reset = 1'b1; #1;
        chk("mid_rst_write", rf_write, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ready", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0; mq.delete(); #1;
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_write", rf_write, 0);

        // Same-register push while that register's entry pops.
        apply(1, 1, 16'h0011, 1, 0); tick();
        apply(1, 1, 16'h0055, 0, 0);
        chk("pp_write", rf_write, 1);
        chk("pp_data0", rf_data, 16'h0011);
        chk("pp_busy0", busy[1], 1);
        tick();
        apply(0, 0, 16'h0, 0, 0);
        chk("pp_count", count, 1);
        chk("pp_busy1", busy[1], 1);
        chk("pp_write1", rf_write, 1);
        chk("pp_data1", rf_data, 16'h0055);
        tick();
        chk("pp_empty", empty, 1);

        // Flush with an offered push.
        apply(1, 0, 16'hF000, 1, 0); tick();
        apply(1, 1, 16'hF001, 1, 0); tick();
        apply(1, 2, 16'hF002, 1, 0); tick();
        apply(1, 3, 16'hDEAD, 0, 1);
        chk("fl_write", rf_write, 0);
        chk("fl_ready", in_ready, 0);
        tick();
        apply(0, 0, 16'h0, 0, 0);
        chk("fl_empty", empty, 1);
        chk("fl_busy", busy, 0);
        chk("fl_count", count, 0);
        chk("fl_write1", rf_write, 0);

`ifdef RF_WB_BYPASS_EN
        apply(1, 1, 16'h0011, 1, 0); tick();
        apply(1, 1, 16'h0022, 1, 0); tick();
        q_addr1 = 1; q_addr2 = 3;
        apply(0, 0, 16'h0, 1, 0);
        chk("byp_hit1", hit1, 1);
        chk("byp_fwd1", fwd_data1, 16'h0022);
        chk("byp_hit2", hit2, 0);
        chk("byp_fwd2", fwd_data2, 0);
        apply(0, 0, 16'h0, 0, 0); tick(); tick();
`endif

        for (int n = 0; n < 400; n++) begin
            q_addr1 = 2'($urandom_range(0, 3));
            q_addr2 = 2'($urandom_range(0, 3));
            apply($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 16'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
            check_model();
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
